half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent half-adder bit lanes; legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the carry-event counter; legal range 4..32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a  input  WIDTH  addend operand, one bit per lane.
REQ-006 b  input  WIDTH  addend operand, one bit per lane.
REQ-007 in_valid  input  1  qualifies a/b for the registered path and counter.
REQ-008 s  output  WIDTH  combinational sum, lane-wise.
REQ-009 c  output  WIDTH  combinational carry, lane-wise.
REQ-010 s_q  output  WIDTH  registered sum.
REQ-011 c_q  output  WIDTH  registered carry.
REQ-012 out_valid  output  1  qualifies s_q/c_q.
REQ-013 carry_count  output  CNT_W  saturating count of accepted cycles with any carry.

Function
REQ-014 s SHALL equal a XOR b per lane, purely combinationally, with zero cycles of latency and independent of clk, rst and in_valid.
REQ-015 c SHALL equal a AND b per lane, purely combinationally, with zero cycles of latency and independent of clk, rst and in_valid.
REQ-016 Lanes SHALL be fully independent, with no carry propagation between lane i and lane i+1.
REQ-017 When in_valid=1 at a rising edge, s_q SHALL load a XOR b and c_q SHALL load a AND b, giving one cycle of latency.
REQ-018 When in_valid=0 at a rising edge, s_q and c_q SHALL hold their previous values.
REQ-019 out_valid SHALL be in_valid delayed by exactly one cycle.
REQ-020 carry_count SHALL increment by 1 on each rising edge where in_valid=1 and c (the reduction-OR of all lanes) is nonzero.
REQ-021 carry_count SHALL saturate at all-ones and never wrap to zero.
REQ-022 Undriven or X inputs are not required to be handled; outputs for such inputs are unspecified.

Reset
REQ-023 On any rising edge with rst=1, s_q, c_q, out_valid and carry_count SHALL all become 0.
REQ-024 rst SHALL take priority over in_valid on the same edge.
REQ-025 The combinational outputs s and c SHALL remain valid during reset.
REQ-026 Deasserting rst mid-stream SHALL resume normal capture on the first edge with rst=0; no cycle is lost or duplicated.

Verification
REQ-027 WIDTH=1, apply a/b = 00, 01, 10, 11 at 2 ns spacing with no clock -> s/c = 0/0, 1/0, 1/0, 0/1 respectively.
REQ-028 WIDTH=1, rst=1 for 2 cycles, then in_valid=1 with a=1, b=1 -> next cycle s_q=0, c_q=1, out_valid=1, carry_count=1.
REQ-029 WIDTH=4, a=4'b1010, b=4'b0110, in_valid=1 -> s=4'b1100, c=4'b0010 immediately; s_q and c_q take the same values after one edge.
REQ-030 CNT_W=4, drive a=b=1 with in_valid=1 for 20 cycles -> carry_count reaches 15 and holds at 15.
REQ-031 Capture a=b=1 with in_valid=1, then drop in_valid and change a/b -> s_q/c_q hold, out_valid=0, carry_count unchanged.
REQ-032 Assert rst on the same edge as in_valid=1 with a=b=1 -> s_q, c_q and carry_count are 0 and out_valid=0 after that edge.

Source files
------------

// File: rtl/half_adder.sv
// Lane-wise half adder: combinational sum/carry, a registered copy qualified
// by in_valid, and a saturating count of accepted cycles that produced any carry.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic any_carry;
  logic cnt_sat;

  // Lanes are bitwise operators only, so nothing ripples between lanes.
  assign s = a ^ b;
  assign c = a & b;

  assign any_carry = |c;
  assign cnt_sat   = (carry_count == CNT_MAX);

  // Valid semantics: there is no ready; a/b are accepted on every rising edge
  // with in_valid=1, and out_valid marks s_q/c_q as holding the result of the
  // edge before. Without in_valid the registered results hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      c_q         <= '0;
      out_valid   <= 1'b0;
      carry_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q <= s;
        c_q <= c;
        if (any_carry && !cnt_sat) begin
          carry_count <= carry_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: a 1-lane instance, a 4-lane instance driven from a
// vector table plus random and hand sequences, and a 4-bit-counter instance.
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // 1-lane instance, default counter width
  logic       rst1, a1, b1, v1, s1, c1, sq1, cq1, ov1;
  logic [15:0] cnt1;
  half_adder #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(v1),
    .s(s1), .c(c1), .s_q(sq1), .c_q(cq1), .out_valid(ov1), .carry_count(cnt1));

  // 4-lane instance
  logic       rst4, v4, ov4;
  logic [3:0] a4, b4, s4, c4, sq4, cq4;
  logic [15:0] cnt4;
  half_adder #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .in_valid(v4),
    .s(s4), .c(c4), .s_q(sq4), .c_q(cq4), .out_valid(ov4), .carry_count(cnt4));

  // 1-lane instance with a 4-bit counter for saturation
  logic       rst_s, as, bs, vs, ss, cs, sqs, cqs, ovs;
  logic [3:0] cnts;
  half_adder #(.WIDTH(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst_s), .a(as), .b(bs), .in_valid(vs),
    .s(ss), .c(cs), .s_q(sqs), .c_q(cqs), .out_valid(ovs), .carry_count(cnts));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       v;
    logic [3:0] es;
    logic [3:0] ec;
  } vec_t;
  vec_t vecs[8];

  // scoreboard / model state for the 4-lane instance
  logic [7:0]  exp_q[$];
  logic        exp_ov;
  logic [15:0] exp_cnt;
  logic [7:0]  last_sc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on the 4-lane instance and update the model.
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic v,
                        input logic r, input logic [3:0] es, input logic [3:0] ec);
    a4 = a; b4 = b; v4 = v; rst4 = r;
    #1;
    chk("w4_s_comb", s4, es);
    chk("w4_c_comb", c4, ec);
    if (r) begin
      exp_q.delete();
      exp_ov  = 1'b0;
      exp_cnt = '0;
      last_sc = '0;
    end else begin
      exp_ov = v;
      if (v) begin
        exp_q.push_back({es, ec});
        if (ec != 4'd0 && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
      end
    end
  endtask

  task automatic tick4();
    logic [7:0] e;
    @(posedge clk);
    #1;
    chk("w4_out_valid", ov4, exp_ov);
    if (ov4) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL w4_sb_empty: out_valid with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("w4_sq_cq", {sq4, cq4}, e);
        last_sc = e;
      end
    end else begin
      chk("w4_hold", {sq4, cq4}, last_sc);
    end
    chk("w4_carry_count", cnt4, exp_cnt);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rv;

    rst1 = 1'b1; a1 = 0; b1 = 0; v1 = 0;
    rst4 = 1'b1; a4 = 0; b4 = 0; v4 = 0;
    rst_s = 1'b1; as = 0; bs = 0; vs = 0;

    vecs[0] = '{4'b1010, 4'b0110, 1'b1, 4'b1100, 4'b0010};
    vecs[1] = '{4'b1111, 4'b0001, 1'b1, 4'b1110, 4'b0001};
    vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b1111};
    vecs[4] = '{4'b0101, 4'b1010, 1'b1, 4'b1111, 4'b0000};
    vecs[5] = '{4'b1100, 4'b0100, 1'b1, 4'b1000, 4'b0100};
    vecs[6] = '{4'b0011, 4'b0000, 1'b0, 4'b0011, 4'b0000};
    vecs[7] = '{4'b1001, 4'b1001, 1'b1, 4'b0000, 4'b1001};

    // combinational truth table, 2 ns spacing, independent of the clock
    a1 = 0; b1 = 0; #1; chk("w1_00", {s1, c1}, 2'b00); #1;
    a1 = 0; b1 = 1; #1; chk("w1_01", {s1, c1}, 2'b10); #1;
    a1 = 1; b1 = 0; #1; chk("w1_10", {s1, c1}, 2'b10); #1;
    a1 = 1; b1 = 1; #1; chk("w1_11", {s1, c1}, 2'b01); #1;

    // reset held two cycles, then one accepted a=b=1
    @(posedge clk); @(posedge clk); #1;
    chk("w1_reset_regs", {sq1, cq1, ov1}, 3'b000);
    chk("w1_reset_cnt", cnt1, 16'd0);
    rst1 = 0; v1 = 1; a1 = 1; b1 = 1;
    @(posedge clk); #1;
    chk("w1_sq_cq", {sq1, cq1}, 2'b01);
    chk("w1_out_valid", ov1, 1'b1);
    chk("w1_carry_count", cnt1, 16'd1);
    v1 = 0;

    // 4-lane: comb outputs valid during reset, then reset state
    drive4(4'b1010, 4'b0110, 1'b1, 1'b1, 4'b1100, 4'b0010);
    tick4();
    tick4();
    chk("w4_reset_cnt", cnt4, 16'd0);

    for (int i = 0; i < 8; i++) begin
      drive4(vecs[i].a, vecs[i].b, vecs[i].v, 1'b0, vecs[i].es, vecs[i].ec);
      tick4();
    end

    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rv = 1'($urandom_range(0, 1));
      drive4(ra, rb, rv, 1'b0, ra ^ rb, ra & rb);
      tick4();
    end

    // capture, then drop in_valid and change inputs: registered side holds
    drive4(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111);
    tick4();
    drive4(4'b0101, 4'b0011, 1'b0, 1'b0, 4'b0110, 4'b0001);
    tick4();
    tick4();

    // reset wins over in_valid on the same edge, then capture resumes at once
    drive4(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b1111);
    tick4();
    chk("w4_rst_prio", {sq4, cq4, ov4}, 9'd0);
    drive4(4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0010, 4'b0001);
    tick4();
    drive4(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick4();
    chk("w4_sb_drained", exp_q.size(), 0);

    // counter saturation at 15 with a 4-bit counter
    @(posedge clk); #1;
    rst_s = 0; as = 1; bs = 1; vs = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      chk("sat_count", cnts, (i > 15) ? 64'd15 : 64'(i));
    end
    vs = 0;
    @(posedge clk); #1;
    chk("sat_hold", cnts, 4'd15);
    chk("sat_out_valid", ovs, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
